// File: rtl/gaussian_window_ctrl.sv
// Pixel-stream front-end for the 7x7 Gaussian core: line buffers,
// sliding window and window-side valid/ready sequencing.
module gaussian_window_ctrl #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int BITS  = 8,
  parameter int WIDTH = 7
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [BITS-1:0]               pix_in,
  input  logic                          pix_valid,
  output logic                          pix_ready,
  output logic [WIDTH*WIDTH*BITS-1:0]   win_data,
  output logic                          win_valid,
  input  logic                          win_ready,
  output logic [$clog2(IMG_H)-1:0]      win_row,
  output logic [$clog2(IMG_W)-1:0]      win_col,
  output logic                          busy,
  output logic                          done
);

  localparam int NLB  = WIDTH - 1;
  localparam int HALF = WIDTH / 2;
  localparam int RW   = $clog2(IMG_H);
  localparam int CW   = $clog2(IMG_W);
  localparam int ROWB = WIDTH * BITS;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t state, state_nxt;

  logic [RW-1:0]          r;
  logic [CW-1:0]          c;
  logic [BITS-1:0]        lb [NLB][IMG_W];
  logic [WIDTH*ROWB-1:0]  win;
  logic [WIDTH*ROWB-1:0]  win_shift;
  logic                   accept;
  logic                   emit;
  logic                   last_pix;
  logic                   done_nxt;

  assign pix_ready = (state == RUN) && (!win_valid || win_ready);
  assign accept    = pix_valid && pix_ready;
  assign emit      = accept
                  && (r >= RW'(WIDTH-1))
                  && (c >= CW'(WIDTH-1));
  assign last_pix  = (r == RW'(IMG_H-1))
                  && (c == CW'(IMG_W-1));
  assign busy      = (state != IDLE);
  assign win_data  = win;

  // Each window row drops its leftmost pixel and takes the new
  // column entry; the bottom row is fed straight from the input.
  for (genvar i = 0; i < WIDTH; i++) begin : g_row
    logic [BITS-1:0] px;
    if (i < NLB) begin : g_lb
      assign px = lb[i][c];
    end else begin : g_in
      assign px = pix_in;
    end
    assign win_shift[(WIDTH-1-i)*ROWB +: ROWB] =
      {win[(WIDTH-1-i)*ROWB +: ROWB-BITS], px};
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < NLB - 1; k++) begin
        lb[k][c] <= lb[k+1][c];
      end
      lb[NLB-1][c] <= pix_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      r         <= '0;
      c         <= '0;
      win       <= '0;
      win_valid <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
      done      <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
      if (state == IDLE && start) begin
        r <= '0;
        c <= '0;
      end else if (accept) begin
        if (c == CW'(IMG_W-1)) begin
          c <= '0;
          r <= (r == RW'(IMG_H-1)) ? '0 : r + 1'b1;
        end else begin
          c <= c + 1'b1;
        end
      end
      if (accept) begin
        win <= win_shift;
      end
      if (emit) begin
        win_valid <= 1'b1;
        win_row   <= r - RW'(HALF);
        win_col   <= c - CW'(HALF);
      end else if (win_valid && win_ready) begin
        win_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        if (accept && last_pix) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!win_valid || win_ready) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_gaussian_window_ctrl.sv
// Scenario-table bench for gaussian_window_ctrl with a window
// scoreboard; covers 8x8 and 7x7 frames.
module tb_gaussian_window_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         start7 = 1'b0;
  logic         pix_valid = 1'b0;
  logic         win_ready = 1'b1;
  logic [7:0]   pix_in = 8'd0;

  logic         pr8, wv8, busy8, done8;
  logic [391:0] wd8;
  logic [2:0]   wr8, wc8;
  logic         pr7, wv7, busy7, done7;
  logic [391:0] wd7;
  logic [2:0]   wr7, wc7;

  always #5 clk = ~clk;

  gaussian_window_ctrl #(
    .IMG_W(8), .IMG_H(8), .BITS(8), .WIDTH(7)
  ) u8 (
    .clk(clk), .rst(rst), .start(start),
    .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(pr8), .win_data(wd8),
    .win_valid(wv8), .win_ready(win_ready),
    .win_row(wr8), .win_col(wc8),
    .busy(busy8), .done(done8)
  );

  gaussian_window_ctrl #(
    .IMG_W(7), .IMG_H(7), .BITS(8), .WIDTH(7)
  ) u7 (
    .clk(clk), .rst(rst), .start(start7),
    .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(pr7), .win_data(wd7),
    .win_valid(wv7), .win_ready(win_ready),
    .win_row(wr7), .win_col(wc7),
    .busy(busy7), .done(done7)
  );

  typedef struct {
    bit gap;
    bit stall;
    bit start_mid;
    bit sel7;
    int exp_win;
  } scen_t;

  typedef struct {
    logic [391:0] d;
    int           row;
    int           col;
  } exp_t;

  exp_t  sb[$];
  scen_t tbl[5];
  int    n_tests = 0;
  int    n_fail = 0;
  bit    sel7 = 1'b0;

  logic         cur_pr, cur_v, cur_busy, cur_done;
  logic [391:0] cur_wd;
  logic [2:0]   cur_row, cur_col;

  always_comb begin
    cur_pr   = sel7 ? pr7   : pr8;
    cur_v    = sel7 ? wv7   : wv8;
    cur_busy = sel7 ? busy7 : busy8;
    cur_done = sel7 ? done7 : done8;
    cur_wd   = sel7 ? wd7   : wd8;
    cur_row  = sel7 ? wr7   : wr8;
    cur_col  = sel7 ? wc7   : wc8;
  end

  task automatic chk(string nm, logic [391:0] got,
                     logic [391:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [391:0] exp_win(int r, int c, int w);
    logic [391:0] v;
    v = '0;
    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < 7; j++) begin
        v[((6-i)*7 + (6-j))*8 +: 8] = 8'((r-6+i)*w + (c-6+j));
      end
    end
    return v;
  endfunction

  task automatic run_frame(input scen_t s);
    int     w, n, k, cyc, stall_left, last_acc, done_at;
    int     nwin, ndone, r, c;
    bit     exp_v, emit, holding;
    logic [391:0] held;
    exp_t   e;
    w = s.sel7 ? 7 : 8;
    n = w * w;
    k = 0; cyc = 0; last_acc = -100; done_at = 0;
    nwin = 0; ndone = 0; exp_v = 0; holding = 0; held = '0;
    stall_left = s.stall ? 5 : 0;
    @(negedge clk);
    pix_valid = 1'b0;
    win_ready = 1'b1;
    if (s.sel7) start7 = 1'b1; else start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    start7 = 1'b0;
    chk("busy_after_start", 392'(cur_busy), 392'(1));
    while (cyc < 3000) begin
      chk("win_valid", 392'(cur_v), 392'(exp_v));
      if (cur_done) begin
        ndone++;
        done_at = cyc;
        break;
      end
      win_ready = !(cur_v && stall_left > 0);
      if (cur_v && stall_left > 0) stall_left--;
      if (k < n) begin
        pix_valid = s.gap ? (cyc % 2 == 0) : 1'b1;
        pix_in = 8'(k);
      end else begin
        pix_valid = 1'b1;
        pix_in = 8'hEE;
      end
      start = !s.sel7 && s.start_mid && (k == 20);
      start7 = s.sel7 && s.start_mid && (k == 20);
      #1;
      if (cur_v && !win_ready) begin
        chk("hold_pix_ready", 392'(cur_pr), 392'(0));
        if (holding) chk("hold_data", cur_wd, held);
        held = cur_wd;
        holding = 1;
      end else begin
        holding = 0;
      end
      if (cur_v && win_ready) begin
        chk("sb_nonempty", 392'(sb.size() > 0), 392'(1));
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("win_data", cur_wd, e.d);
          chk("win_row", 392'(cur_row), 392'(e.row));
          chk("win_col", 392'(cur_col), 392'(e.col));
          nwin++;
        end
      end
      emit = 0;
      if (k >= n) begin
        chk("drain_pix_ready", 392'(cur_pr), 392'(0));
      end else if (pix_valid && cur_pr) begin
        r = k / w;
        c = k % w;
        if (r >= 6 && c >= 6) begin
          e.d = exp_win(r, c, w);
          e.row = r - 3;
          e.col = c - 3;
          sb.push_back(e);
          emit = 1;
        end
        if (k == n - 1) last_acc = cyc;
        k++;
      end
      exp_v = emit ? 1'b1 : (exp_v && win_ready) ? 1'b0 : exp_v;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    start7 = 1'b0;
    pix_valid = 1'b0;
    chk("done_count", 392'(ndone), 392'(1));
    chk("done_latency", 392'(done_at - last_acc), 392'(2));
    chk("window_count", 392'(nwin), 392'(s.exp_win));
    chk("sb_empty", 392'(sb.size()), 392'(0));
    sb.delete();
    @(negedge clk);
    chk("done_pulse_end", 392'(cur_done), 392'(0));
    chk("busy_end", 392'(cur_busy), 392'(0));
  endtask

  initial begin
    int acc, cyc;
    tbl[0] = '{gap: 0, stall: 0, start_mid: 0, sel7: 0, exp_win: 4};
    tbl[1] = '{gap: 0, stall: 1, start_mid: 0, sel7: 0, exp_win: 4};
    tbl[2] = '{gap: 1, stall: 0, start_mid: 0, sel7: 0, exp_win: 4};
    tbl[3] = '{gap: 0, stall: 0, start_mid: 1, sel7: 0, exp_win: 4};
    tbl[4] = '{gap: 0, stall: 0, start_mid: 0, sel7: 1, exp_win: 1};

    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_pix_ready", 392'(pr8), 392'(0));
    chk("rst_win_valid", 392'(wv8), 392'(0));
    chk("rst_busy", 392'(busy8), 392'(0));
    chk("rst_done", 392'(done8), 392'(0));
    chk("rst_win_data", wd8, 392'(0));
    chk("rst_win_rc", 392'({wr8, wc8}), 392'(0));
    chk("rst7_busy", 392'(busy7), 392'(0));
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      sel7 = tbl[i].sel7;
      run_frame(tbl[i]);
    end

    sel7 = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    acc = 0;
    cyc = 0;
    while (acc < 30 && cyc < 200) begin
      pix_valid = 1'b1;
      pix_in = 8'(acc);
      #1;
      if (pr8) acc++;
      @(negedge clk);
      cyc++;
    end
    chk("abort_accepts", 392'(acc), 392'(30));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_pix_ready", 392'(pr8), 392'(0));
    chk("abort_win_valid", 392'(wv8), 392'(0));
    chk("abort_busy", 392'(busy8), 392'(0));
    chk("abort_done", 392'(done8), 392'(0));
    pix_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_done", 392'(done8), 392'(0));
    end

    run_frame(tbl[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
